hlsm_launcher: RTL
==================

Name: hlsm_launcher

Overview:
- Initiator side of the HLSM Start/Done protocol; the HLSM itself is the responder.
- Accepts an operand job (a, b, c) on a valid/ready input port and drives registered operands to the HLSM. Pulses Start, waits for Done, then captures the z and x results.
- Returns results on a valid/ready output port.
- Sits between the testbench/system bus and one HLSM instance.
- Serialises jobs: only one job is in flight at a time.

Parameters:
- DATAWIDTH, 16, width of operands a/b/c and of result x.
- ZWIDTH, 8, width of result z.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit before abort (used only with HLSM_TIMEOUT_EN).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  launcher can accept a job.
- in_a, in_b, in_c  in  DATAWIDTH each  job operands.
- hls_start  out  1  Start to HLSM.
- hls_done  in  1  Done from HLSM.
- hls_a, hls_b, hls_c  out  DATAWIDTH each  registered operands to HLSM.
- hls_z  in  ZWIDTH  HLSM result z.
- hls_x  in  DATAWIDTH  HLSM result x.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_z  out  ZWIDTH  captured z.
- out_x  out  DATAWIDTH  captured x.
- out_err  out  1  result aborted by timeout (constant 0 without HLSM_TIMEOUT_EN).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE. in_ready=1, hls_start=0, out_valid=0, out_err=0, busy=0. hls_a/b/c=0, out_z=0, out_x=0.
- States: IDLE, LAUNCH, WAIT, HOLD. The encoding is a 2-bit enum.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a/b/c into hls_a/b/c and go to LAUNCH.
- LAUNCH:
  - hls_start=1 for exactly one cycle.
  - hls_done is ignored in this cycle; a stale Done must not complete the job.
  - Always goes to WAIT.
- WAIT:
  - hls_start=0.
  - On hls_done=1: capture hls_z→out_z and hls_x→out_x, set out_valid=1 next cycle, go to HOLD.
- HOLD:
  - out_valid=1 and out_z/out_x are held stable.
  - On out_ready: clear out_valid and out_err, go to IDLE.
- Operand stability: hls_a/b/c are held constant from LAUNCH until return to IDLE.
- in_ready is 0 in every state except IDLE.
- Latency:
  - Job accepted at edge N → hls_start high in cycle N+1.
  - Done first seen at edge M (M ≥ N+2) → out_valid high from cycle M+1.
  - Minimum total latency is 3 cycles.
- Back-to-back: the earliest next acceptance is the cycle after an out_ready handshake; there is no IDLE skip.
- Done is level-sampled, so Done held high across jobs completes each WAIT on its first cycle.
- No arithmetic is performed; all widths pass straight through.

Optional Feature:
- Macro: HLSM_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter runs.
  - If hls_done is still 0 after TIMEOUT_CYCLES WAIT cycles: go to HOLD with out_err=1 and out_z/out_x=0.
  - The counter clears on entry to WAIT.
  - If Done arrives on the same cycle as expiry, Done wins and out_err=0.
- Undefined: WAIT is unbounded, out_err is tied to 0, and no counter logic is present.

Decomposition:
- Package hlsm_launch_pkg holds:
  - state_t enum (IDLE, LAUNCH, WAIT, HOLD);
  - default width constants;
  - timeout counter width, computed as $clog2(TIMEOUT_CYCLES+1).
- One sub-module, hlsm_watchdog (counter, clear, expire flag), instantiated only under HLSM_TIMEOUT_EN.

Test Plan:
- Basic job: reset, then a=3, b=4, c=5.
  - HLSM model asserts Done 2 cycles after Start with z=0x07, x=0x0008.
  - Required: hls_start high for exactly 1 cycle; out_valid with out_z=0x07, out_x=0x0008, out_err=0.
- Stale Done: hls_done held 1 during LAUNCH.
  - Required: no completion in LAUNCH; completion on the first WAIT cycle; out_valid appears 3 cycles after acceptance.
- Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 with new operands.
  - Required: out_z/out_x stable, in_ready=0, hls_a/b/c unchanged.
  - After the out_ready handshake, the next job is accepted one cycle later.
- Reset mid-operation: assert Rst during WAIT.
  - Required: same cycle (async) hls_start=0, out_valid=0, in_ready=1, hls_a/b/c=0.
  - After release, a new job runs normally.
- Timeout (HLSM_TIMEOUT_EN, TIMEOUT_CYCLES=8): Done never asserted.
  - Required: out_valid with out_err=1, out_z=0, out_x=0 after 8 WAIT cycles.
  - Repeat with Done exactly on expiry: result captured, out_err=0.
- Throughput: 10 back-to-back jobs with random operands and random Done delay 1–20.
  - Required: results in order and matching the reference model; exactly 10 Start pulses.

Source files
------------

// File: rtl/hlsm_launch_pkg.sv
// Shared types and defaults for the HLSM Start/Done launcher.
package hlsm_launch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_DATAWIDTH      = 16;
  localparam int unsigned DEF_ZWIDTH         = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hlsm_watchdog.sv
// WAIT-state cycle counter; expired is high on the last permitted WAIT cycle.
module hlsm_watchdog
  import hlsm_launch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = timeout_cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hlsm_launcher.sv
// Initiator for the HLSM Start/Done handshake, one job in flight at a time.
// Optional WAIT-state watchdog enabled by defining HLSM_TIMEOUT_EN.
module hlsm_launcher
  import hlsm_launch_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = DEF_DATAWIDTH,
  parameter int unsigned ZWIDTH         = DEF_ZWIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  input  logic [DATAWIDTH-1:0] in_c,
  output logic                 hls_start,
  input  logic                 hls_done,
  output logic [DATAWIDTH-1:0] hls_a,
  output logic [DATAWIDTH-1:0] hls_b,
  output logic [DATAWIDTH-1:0] hls_c,
  input  logic [ZWIDTH-1:0]    hls_z,
  input  logic [DATAWIDTH-1:0] hls_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ZWIDTH-1:0]    out_z,
  output logic [DATAWIDTH-1:0] out_x,
  output logic                 out_err,
  output logic                 busy
);

  state_t state, state_next;
  logic   timeout;

`ifdef HLSM_TIMEOUT_EN
  logic err;

  // Counter is held clear outside WAIT, so it restarts from zero on every entry.
  hlsm_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (state != WAIT),
    .run    (state == WAIT),
    .expired(timeout)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err <= 1'b0;
    end else if (state == WAIT) begin
      err <= timeout && !hls_done;
    end else if (state == HOLD && out_ready) begin
      err <= 1'b0;
    end
  end

  assign out_err = err;
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (hls_done || timeout) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    hls_start = (state == LAUNCH);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Done has priority over expiry; an expired job returns zeroed results.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hls_a <= '0;
      hls_b <= '0;
      hls_c <= '0;
      out_z <= '0;
      out_x <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        hls_a <= in_a;
        hls_b <= in_b;
        hls_c <= in_c;
      end
      if (state == WAIT) begin
        if (hls_done) begin
          out_z <= hls_z;
          out_x <= hls_x;
        end else if (timeout) begin
          out_z <= '0;
          out_x <= '0;
        end
      end
    end
  end

endmodule
